// File: rtl/execute_mem_lsu_pkg.sv
// execute_mem_lsu_pkg: shared widths, opcodes, FSM states and fault causes
// for the handshaked load/store execute unit.
package execute_mem_lsu_pkg;

    localparam int DEF_LEN_OPECODE   = 6;
    localparam int DEF_LEN_REG       = 32;
    localparam int DEF_LEN_IMM_EX    = 16;
    localparam int DEF_MEM_DATA_ADDR = 16;
    localparam int DEF_TIMEOUT       = 15;

    localparam logic [DEF_LEN_OPECODE-1:0] OPECODE_LD = 6'h23;
    localparam logic [DEF_LEN_OPECODE-1:0] OPECODE_ST = 6'h2b;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    typedef enum logic [1:0] {FAULT_NONE, FAULT_RANGE, FAULT_OPC, FAULT_TIMEOUT} fault_e;

endpackage

// File: rtl/execute_mem_agu.sv
// execute_mem_agu: base select, sign-extended offset add and range/opcode
// check for one LD/ST; purely combinational.
module execute_mem_agu
    import execute_mem_lsu_pkg::*;
#(
    parameter int LEN_OPECODE   = DEF_LEN_OPECODE,
    parameter int LEN_REG       = DEF_LEN_REG,
    parameter int LEN_IMM_EX    = DEF_LEN_IMM_EX,
    parameter int MEM_DATA_ADDR = DEF_MEM_DATA_ADDR
) (
    input  logic [LEN_OPECODE-1:0]   opecode,
    input  logic [LEN_REG-1:0]       data_rd,
    input  logic [LEN_REG-1:0]       data_rs,
    input  logic [LEN_IMM_EX-1:0]    imm_ex,
    output logic [MEM_DATA_ADDR-1:0] addr,
    output logic                     we,
    output fault_e                   cause
);

    logic               is_ld;
    logic               is_st;
    logic [LEN_REG-1:0] sum;

    always_comb begin
        is_ld = opecode == LEN_OPECODE'(OPECODE_LD);
        is_st = opecode == LEN_OPECODE'(OPECODE_ST);
        sum   = (is_st ? data_rd : data_rs)
              + {{(LEN_REG-LEN_IMM_EX){imm_ex[LEN_IMM_EX-1]}}, imm_ex};
        addr  = sum[MEM_DATA_ADDR-1:0];
        we    = is_st;
        // Any set bit above the word address, including a negative wrap, is out of range.
        if (!(is_ld || is_st))
            cause = FAULT_OPC;
        else if (|sum[LEN_REG-1:MEM_DATA_ADDR])
            cause = FAULT_RANGE;
        else
            cause = FAULT_NONE;
    end

endmodule

// File: rtl/execute_mem_lsu.sv
// execute_mem_lsu: one-in-flight LD/ST execute unit with request/grant memory
// port, variable read latency, response watchdog and valid/ready writeback.
module execute_mem_lsu
    import execute_mem_lsu_pkg::*;
#(
    parameter int LEN_OPECODE   = DEF_LEN_OPECODE,
    parameter int LEN_REG       = DEF_LEN_REG,
    parameter int LEN_IMM_EX    = DEF_LEN_IMM_EX,
    parameter int MEM_DATA_ADDR = DEF_MEM_DATA_ADDR,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LEN_OPECODE-1:0]   opecode,
    input  logic [LEN_REG-1:0]       data_rd,
    input  logic [LEN_REG-1:0]       data_rs,
    input  logic [LEN_IMM_EX-1:0]    imm_ex,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic                     mem_we,
    output logic [MEM_DATA_ADDR-1:0] mem_addr,
    output logic [LEN_REG-1:0]       mem_wdata,
    input  logic                     mem_rvalid,
    input  logic [LEN_REG-1:0]       mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LEN_REG-1:0]       data_o,
    output logic                     fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e                   state;
    state_e                   state_n;
    logic [CW-1:0]            cnt;
    logic [MEM_DATA_ADDR-1:0] agu_addr;
    logic                     agu_we;
    fault_e                   agu_cause;
    logic                     accept;
    logic                     timeout;

    execute_mem_agu #(
        .LEN_OPECODE  (LEN_OPECODE),
        .LEN_REG      (LEN_REG),
        .LEN_IMM_EX   (LEN_IMM_EX),
        .MEM_DATA_ADDR(MEM_DATA_ADDR)
    ) u_agu (
        .opecode(opecode),
        .data_rd(data_rd),
        .data_rs(data_rs),
        .imm_ex (imm_ex),
        .addr   (agu_addr),
        .we     (agu_we),
        .cause  (agu_cause)
    );

    assign accept    = in_valid && in_ready;
    assign timeout   = cnt == CW'(TIMEOUT - 1);
    assign mem_req   = state == REQ;
    assign out_valid = state == RESP;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (agu_cause != FAULT_NONE) ? RESP : REQ;
            REQ:     if (mem_gnt) state_n = mem_we ? RESP : WAIT;
            WAIT:    if (mem_rvalid || timeout) state_n = RESP;
            RESP:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // in_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            data_o    <= '0;
            fault     <= 1'b0;
        end else begin
            in_ready <= state_n == IDLE;
            cnt      <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (accept) begin
                mem_addr  <= agu_addr;
                mem_we    <= agu_we;
                mem_wdata <= data_rs;
                data_o    <= '0;
                fault     <= agu_cause != FAULT_NONE;
            end
            if (state == WAIT && mem_rvalid)
                data_o <= mem_rdata;
            else if (state == WAIT && timeout)
                fault <= 1'b1;
        end
    end

endmodule

// File: doc/execute_mem_lsu.md
# execute_mem_lsu

Parametrised, handshaked load/store execute unit; successor to the single-cycle memory execute stage. Accepts one LD/ST per transaction from the issue stage, forms and range-checks the effective address, and drives an external data-memory port with request/grant and variable read latency. Returns load data or a fault to writeback over a valid/ready channel, with a watchdog on missing read responses.

## Interface
- LEN_OPECODE, 6: opecode width (from instruction defs)
- LEN_REG, 32: register/data width
- LEN_IMM_EX, 16: immediate width, sign-extended to LEN_REG
- MEM_DATA_ADDR, 16: memory word-address width; MEM_DATA_ADDR < LEN_REG
- TIMEOUT, 15: max cycles in WAIT before fault; TIMEOUT >= 1
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1  issue handshake
- opecode  in  LEN_OPECODE  OPECODE_LD or OPECODE_ST
- data_rd, data_rs  in  LEN_REG  base regs: LD base = data_rs; ST base = data_rd, store data = data_rs
- imm_ex  in  LEN_IMM_EX  signed offset
- mem_req / mem_gnt  out / in  1  memory request handshake
- mem_we  out  1  1 = store
- mem_addr  out  MEM_DATA_ADDR  word address
- mem_wdata  out  LEN_REG  store data
- mem_rvalid / mem_rdata  in  1 / LEN_REG  load response, one cycle pulse
- out_valid / out_ready  out / in  1  writeback handshake
- data_o  out  LEN_REG  load data; 0 for stores and faults
- fault  out  1  qualified by out_valid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid: register opecode, address, store data.
- Effective address = base + sign_ext(imm_ex), computed at LEN_REG bits, two's complement wrap.
- Fault if bits [LEN_REG-1:MEM_DATA_ADDR] of the sum are nonzero (covers negative), or opecode is neither LD nor ST. Faulting op goes IDLE->RESP, fault=1, data_o=0, no memory access.
- Legal op: IDLE->REQ. REQ: mem_req=1, address/we/wdata stable until mem_gnt sampled high.
- ST + gnt: REQ->RESP, fault=0, data_o=0.
- LD + gnt: REQ->WAIT, timeout counter cleared. WAIT: on mem_rvalid capture mem_rdata, ->RESP. Counter reaching TIMEOUT without rvalid: ->RESP with fault=1, data_o=0.
- mem_rvalid outside WAIT is ignored (includes stale responses after timeout or reset).
- RESP: out_valid=1, data_o/fault held until out_ready; then ->IDLE. No new op accepted in RESP (one transaction in flight).

## Timing
- Reset values: in_ready=0 during reset, 1 in first cycle after release (IDLE); mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, data_o=0, fault=0; state=IDLE; counter=0.
- All outputs registered or decoded from state only; no combinational path in_valid->mem_req or mem_rvalid->out_valid.
- Minimum LD latency: accept cycle 0, mem_req cycle 1 (gnt same cycle), rvalid cycle 2, out_valid cycle 3.
- Minimum ST latency: accept cycle 0, req+gnt cycle 1, out_valid cycle 2. Fault: out_valid cycle 1.
- Throughput: one op per (latency + 1) cycles with out_ready held high.
- Async reset mid-transaction aborts immediately; outstanding memory response is dropped.

## Structure
- Shared package: OPECODE_LD/OPECODE_ST, LEN_* widths, FSM state enum, fault-cause constants.
- One combinational sub-module natural: execute_mem_agu (base select, sign-extend, add, range check -> addr, fault).

## Test plan
- LD rs=0x100, imm=4, gnt immediate, rvalid next cycle rdata=0xDEADBEEF -> mem_addr=0x104, we=0, out_valid cycle 3, data_o=0xDEADBEEF, fault=0.
- ST rd=0x10, imm=-1, rs=0x55 -> mem_addr=0x000F, we=1, wdata=0x55, out_valid cycle 2, data_o=0.
- LD rs=0, imm=-1 (negative) and rs=0x10000 -> no mem_req, fault=1 at cycle 1.
- LD with gnt withheld 3 cycles, out_ready withheld 2 cycles -> req/addr stable, out_valid/data_o held, in_ready=0 throughout.
- LD, no rvalid -> fault=1 after TIMEOUT cycles in WAIT; late rvalid then ignored, next op correct.
- Assert rst_n=0 during WAIT -> all outputs to reset values same cycle; rvalid after release ignored.
